// File: rtl/ov7670_cfg_sequencer_if.sv
// ov7670_cfg_sequencer_if: SCCB write request/completion handshake between the
// config sequencer (master) and the SCCB write engine (slave).
interface ov7670_cfg_sequencer_if;
  logic       sccb_valid;
  logic       sccb_ready;
  logic [7:0] sccb_reg;
  logic [7:0] sccb_val;
  logic       sccb_done;
  logic       sccb_nack;
  modport master (output sccb_valid, sccb_reg, sccb_val, input sccb_ready, sccb_done, sccb_nack);
  modport slave (input sccb_valid, sccb_reg, sccb_val, output sccb_ready, sccb_done, sccb_nack);
endinterface

// File: rtl/ov7670_cfg_sequencer.sv
// ov7670_cfg_sequencer: walks the OV7670 register ROM and issues one SCCB write per entry.
// Define OV7670_CFG_RETRY_EN to re-issue NACKed writes up to MAX_RETRY times.
module ov7670_cfg_sequencer #(
  parameter int NUM_REGS = 23,
  parameter int ADDR_W   = 5,
  parameter int RST_WAIT = 25000,
  parameter int GAP_WAIT = 16
`ifdef OV7670_CFG_RETRY_EN
  , parameter int MAX_RETRY = 3
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [15:0]            rom_data,
  ov7670_cfg_sequencer_if.master sccb,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, LATCH = 3'd2, ISSUE = 3'd3,
                         WAIT_ACK = 3'd4, DELAY = 3'd5, DONE = 3'd6;
  localparam int CW = $clog2((RST_WAIT > GAP_WAIT ? RST_WAIT : GAP_WAIT) + 1);
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          last;
  logic          soft_rst;
  assign last     = rom_addr == ADDR_W'(NUM_REGS - 1);
  // COM7 with bit 7 set resets the sensor, which needs time to settle
  assign soft_rst = sccb.sccb_reg == 8'h12 && sccb.sccb_val[7];
`ifdef OV7670_CFG_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 2);
  logic [RW-1:0] tries;
  logic          again;
  logic          retry;
  assign retry = sccb.sccb_nack && tries < RW'(MAX_RETRY);
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      rom_addr        <= '0;
      sccb.sccb_valid <= 1'b0;
      sccb.sccb_reg   <= '0;
      sccb.sccb_val   <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      cnt             <= '0;
`ifdef OV7670_CFG_RETRY_EN
      tries           <= '0;
      again           <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          rom_addr <= '0;
          busy     <= 1'b1;
          done     <= 1'b0;
          err      <= 1'b0;
          state    <= FETCH;
`ifdef OV7670_CFG_RETRY_EN
          tries    <= '0;
          again    <= 1'b0;
`endif
        end
        FETCH: state <= LATCH;
        LATCH: begin
          sccb.sccb_reg <= rom_data[7:0];
          sccb.sccb_val <= rom_data[15:8];
          if (rom_data == 16'hFFFF) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state           <= ISSUE;
            sccb.sccb_valid <= 1'b1;
          end
        end
        ISSUE: if (sccb.sccb_ready) begin
          sccb.sccb_valid <= 1'b0;
          state           <= WAIT_ACK;
        end
        WAIT_ACK: if (sccb.sccb_done) begin
          state <= DELAY;
          cnt   <= soft_rst ? CW'(RST_WAIT) : CW'(GAP_WAIT);
`ifdef OV7670_CFG_RETRY_EN
          if (retry) begin
            tries <= tries + RW'(1);
            again <= 1'b1;
            cnt   <= CW'(GAP_WAIT);
          end else if (sccb.sccb_nack) err <= 1'b1;
`else
          if (sccb.sccb_nack) err <= 1'b1;
`endif
        end
        DELAY: if (cnt > CW'(1)) cnt <= cnt - CW'(1);
        else begin
          cnt <= '0;
`ifdef OV7670_CFG_RETRY_EN
          if (again) begin
            again           <= 1'b0;
            state           <= ISSUE;
            sccb.sccb_valid <= 1'b1;
          end else
`endif
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            rom_addr <= rom_addr + ADDR_W'(1);
            state    <= FETCH;
`ifdef OV7670_CFG_RETRY_EN
            tries    <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
